// File: rtl/heartbeat_gen_pkg.sv
// heartbeat_gen shared definitions: FSM state encoding and default timing.
// Defaults give a 1 kHz, 50% duty heartbeat from the 50 MHz oscillator.
package heartbeat_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STARVED = 2'd2
    } hb_state_e;

    localparam int unsigned SYS_CLK_HZ  = 50_000_000;
    localparam int unsigned HB_FREQ_HZ  = 1_000;

    localparam int unsigned DEFAULT_PERIOD       = SYS_CLK_HZ / HB_FREQ_HZ;
    localparam int unsigned DEFAULT_HIGH_CYCLES  = DEFAULT_PERIOD / 2;
    localparam int unsigned DEFAULT_KICK_TIMEOUT = 100;

endpackage

// File: rtl/heartbeat_gen_if.sv
// heartbeat_gen control/status bundle.
// master: CPU side (drives en/kick); slave: heartbeat_gen (drives pwm/status).
interface heartbeat_gen_if;

    logic en;
    logic kick;
    logic pwm;
    logic running;
    logic starved;
    logic period_tick;

    modport master (
        output en, kick,
        input  pwm, running, starved, period_tick
    );

    modport slave (
        input  en, kick,
        output pwm, running, starved, period_tick
    );

endinterface

// File: rtl/hb_period_counter.sv
// Heartbeat phase counter: counts 0..PERIOD-1 while running, wraps at the end.
// Ports: clk, rst, i_clear (force 0), i_run (advance), o_phase, o_boundary.
module hb_period_counter #(
    parameter int unsigned PERIOD = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_run,
    output logic [31:0] o_phase,
    output logic        o_boundary
);

    localparam logic [31:0] LAST = 32'(PERIOD - 1);

    logic [31:0] r_phase;

    assign o_phase    = r_phase;
    assign o_boundary = (r_phase == LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_phase <= '0;
        end else if (i_run) begin
            r_phase <= o_boundary ? '0 : r_phase + 32'd1;
        end
    end

endmodule

// File: rtl/heartbeat_gen.sv
// Heartbeat square-wave generator gated by enable and a watchdog kick.
// Ports: clk, rst (sync, active-high), hb (slave: en, kick -> pwm, running, starved, period_tick).
module heartbeat_gen
    import heartbeat_gen_pkg::*;
#(
    parameter int unsigned PERIOD       = DEFAULT_PERIOD,
    parameter int unsigned HIGH_CYCLES  = DEFAULT_HIGH_CYCLES,
    parameter int unsigned KICK_TIMEOUT = DEFAULT_KICK_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    heartbeat_gen_if.slave hb
);

    if (PERIOD < 2 || HIGH_CYCLES == 0 || HIGH_CYCLES >= PERIOD) begin : g_bad_params
        $fatal(1, "heartbeat_gen: illegal PERIOD/HIGH_CYCLES");
    end

    localparam bit          WD_ON = (KICK_TIMEOUT != 0);
    localparam logic [31:0] HI    = 32'(HIGH_CYCLES);
    localparam logic [31:0] KT32  = 32'(KICK_TIMEOUT);
    localparam logic [32:0] KT33  = {1'b0, KT32};

    hb_state_e   r_state;
    hb_state_e   w_state_next;
    logic [31:0] r_kick_cnt;
    logic [31:0] w_kick_cnt_next;
    logic [31:0] w_phase;
    logic [31:0] w_phase_next;
    logic [32:0] w_cnt_inc;
    logic        w_boundary;
    logic        w_kick;
    logic        w_timeout;
    logic        w_run_next;
    logic        r_pwm;
    logic        r_running;
    logic        r_starved;
    logic        r_tick;

    // With the watchdog disabled kicks are ignored and kick_cnt stays 0.
    assign w_kick     = WD_ON && hb.kick;
    // 33-bit increment so the timeout compare cannot wrap.
    assign w_cnt_inc  = {1'b0, r_kick_cnt} + 33'd1;
    assign w_timeout  = WD_ON && (w_cnt_inc >= KT33);
    assign w_run_next = (w_state_next == ST_RUN);

    hb_period_counter #(
        .PERIOD (PERIOD)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (!w_run_next),
        .i_run      (r_state == ST_RUN),
        .o_phase    (w_phase),
        .o_boundary (w_boundary)
    );

    always_comb begin
        w_state_next    = r_state;
        w_phase_next    = '0;
        w_kick_cnt_next = w_kick ? '0 : r_kick_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (hb.en) begin
                    w_state_next    = ST_RUN;
                    w_kick_cnt_next = '0;
                end
            end
            ST_RUN: begin
                if (!w_boundary) begin
                    w_phase_next = w_phase + 32'd1;
                end else if (!hb.en) begin
                    // Stop only at the boundary so no runt pulse is emitted.
                    w_state_next = ST_IDLE;
                end else if (w_timeout && !w_kick) begin
                    w_state_next    = ST_STARVED;
                    w_kick_cnt_next = KT32;
                end else if (!w_kick && WD_ON) begin
                    w_kick_cnt_next = w_cnt_inc[31:0];
                end
            end
            ST_STARVED: begin
                if (!hb.en) begin
                    w_state_next = ST_IDLE;
                end else if (w_kick) begin
                    w_state_next    = ST_RUN;
                    w_kick_cnt_next = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_kick_cnt <= '0;
            r_pwm      <= 1'b0;
            r_running  <= 1'b0;
            r_starved  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_kick_cnt <= w_kick_cnt_next;
            r_pwm      <= w_run_next && (w_phase_next < HI);
            r_running  <= w_run_next;
            r_starved  <= (w_state_next == ST_STARVED);
            // Phase 0 in RUN is always a fresh period start (PERIOD >= 2).
            r_tick     <= w_run_next && (w_phase_next == '0);
        end
    end

    assign hb.pwm         = r_pwm;
    assign hb.running     = r_running;
    assign hb.starved     = r_starved;
    assign hb.period_tick = r_tick;

endmodule

// File: tb/tb_heartbeat_gen.sv
// Self-checking bench for heartbeat_gen: directed scenarios plus random stimulus
// against a behavioural model; one DUT with watchdog, one with it disabled.
module tb_heartbeat_gen;

    localparam int P  = 10;
    localparam int H  = 4;
    localparam int KT = 3;
    localparam int HN = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    heartbeat_gen_if ifa ();
    heartbeat_gen_if ifb ();

    heartbeat_gen #(
        .PERIOD       (P),
        .HIGH_CYCLES  (H),
        .KICK_TIMEOUT (KT)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .hb  (ifa)
    );

    heartbeat_gen #(
        .PERIOD       (P),
        .HIGH_CYCLES  (H),
        .KICK_TIMEOUT (0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .hb  (ifb)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model state: mode 0 idle, 1 run, 2 starved; ph = cycles into the period;
    // kc = whole periods since last kick.
    int m_st [2] = '{0, 0};
    int m_ph [2] = '{0, 0};
    int m_kc [2] = '{0, 0};
    bit e_pwm [2] = '{0, 0};
    bit e_run [2] = '{0, 0};
    bit e_stv [2] = '{0, 0};
    bit e_tick[2] = '{0, 0};

    logic pa [HN];
    logic ta [HN];
    logic sa [HN];
    logic ra [HN];
    logic pb [HN];
    logic sb [HN];

    initial begin
        for (int i = 0; i < HN; i++) begin
            pa[i] = 0; ta[i] = 0; sa[i] = 0;
            ra[i] = 0; pb[i] = 0; sb[i] = 0;
        end
    end

    task automatic ck(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, $signed(act), $signed(exp), cyc);
        end
    endtask

    task automatic model_step(input int i, input int kt, input bit r,
                              input bit e, input bit k);
        int st;
        int ph;
        int kc;
        bit old;
        st = m_st[i]; ph = m_ph[i]; kc = m_kc[i];
        if (r) begin
            st = 0; ph = 0; kc = 0;
        end else if (st == 0) begin
            if (e) begin st = 1; ph = 0; kc = 0; end
        end else if (st == 1) begin
            if (ph == P - 1) begin
                if (!e) begin
                    st = 0; ph = 0;
                end else if (kt != 0 && !k && kc + 1 >= kt) begin
                    st = 2; ph = 0;
                end else begin
                    ph = 0;
                    kc = k ? 0 : kc + 1;
                end
            end else begin
                ph = ph + 1;
                if (k) kc = 0;
            end
        end else begin
            if (!e) st = 0;
            else if (k && kt != 0) begin st = 1; ph = 0; kc = 0; end
        end
        old = e_pwm[i];
        m_st[i] = st; m_ph[i] = ph; m_kc[i] = kc;
        e_pwm[i]  = (st == 1) && (ph < H);
        e_run[i]  = (st == 1);
        e_stv[i]  = (st == 2);
        e_tick[i] = e_pwm[i] && !old;
    endtask

    task automatic step(input bit r, input bit e, input bit k);
        rst = r;
        ifa.en = e; ifa.kick = k;
        ifb.en = e; ifb.kick = k;
        model_step(0, KT, r, e, k);
        model_step(1, 0, r, e, k);
        @(posedge clk);
        #1;
        cyc++;
        ck("a_pwm",  ifa.pwm,         e_pwm[0]);
        ck("a_run",  ifa.running,     e_run[0]);
        ck("a_stv",  ifa.starved,     e_stv[0]);
        ck("a_tick", ifa.period_tick, e_tick[0]);
        ck("b_pwm",  ifb.pwm,         e_pwm[1]);
        ck("b_run",  ifb.running,     e_run[1]);
        ck("b_stv",  ifb.starved,     e_stv[1]);
        ck("b_tick", ifb.period_tick, e_tick[1]);
        if (cyc < HN) begin
            pa[cyc] = ifa.pwm;     ta[cyc] = ifa.period_tick;
            sa[cyc] = ifa.starved; ra[cyc] = ifa.running;
            pb[cyc] = ifb.pwm;     sb[cyc] = ifb.starved;
        end
    endtask

    function automatic logic get(input int sel, input int i);
        case (sel)
            0: return pa[i];
            1: return ta[i];
            2: return sa[i];
            3: return ra[i];
            4: return pb[i];
            default: return sb[i];
        endcase
    endfunction

    function automatic int sum(input int sel, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (get(sel, i)) c++;
        return c;
    endfunction

    function automatic int rises(input int sel, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++)
            if (get(sel, i) && !get(sel, i - 1)) c++;
        return c;
    endfunction

    function automatic int first_rise(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            if (pa[i] && !pa[i - 1]) return i;
        return -1;
    endfunction

    initial begin
        int b;
        int prev;
        int bad;
        bit en_r;

        // 1: reset then start at cycle 10, kicks every 20 cycles
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        ck("s1_reset_out", {28'd0, pa[3], ra[3], sa[3], ta[3]}, 0);
        while (cyc < 45) step(0, cyc >= 10, cyc == 20 || cyc == 40);
        ck("s1_rise11", first_rise(1, 15), 11);
        ck("s1_rise21", first_rise(12, 25), 21);
        ck("s1_rise31", first_rise(22, 35), 31);
        ck("s1_high4",  sum(0, 21, 30), 4);
        ck("s1_ticks",  sum(1, 1, 40), 3);
        ck("s1_tick31", ta[31], 1);

        // 2: clean stop at phase 2, then an en glitch inside a period
        while (cyc < 53) step(0, 1, 0);
        while (cyc < 70) step(0, 0, 0);
        ck("s2_last_high", sum(0, 51, 60), 4);
        ck("s2_no_rise",   rises(0, 52, 70), 0);
        ck("s2_run60",     ra[60], 1);
        ck("s2_run61",     ra[61], 0);
        while (cyc < 73) step(0, 1, 0);
        while (cyc < 75) step(0, 0, 0);
        while (cyc < 86) step(0, 1, cyc == 80);
        ck("s2_glitch_high", sum(0, 71, 80), 4);
        ck("s2_glitch_rise", first_rise(72, 85), 81);

        // 3: watchdog starve, then recover with a kick
        step(1, 0, 0); step(1, 0, 0);
        b = cyc;
        while (cyc < b + 50) step(0, 1, 0);
        step(0, 1, 1);
        while (cyc < b + 61) step(0, 1, 0);
        ck("s3_three",     rises(0, b + 1, b + 50), 3);
        ck("s3_stv_pre",   sa[b + 30], 0);
        ck("s3_stv_on",    sa[b + 31], 1);
        ck("s3_pwm_quiet", sum(0, b + 31, b + 50), 0);
        ck("s3_recover",   first_rise(b + 31, b + 60), b + 51);
        ck("s3_stv_off",   sa[b + 51], 0);
        ck("s3_run_on",    ra[b + 51], 1);

        // 4: kick on the third timeout boundary
        step(1, 0, 0); step(1, 0, 0);
        b = cyc;
        while (cyc < b + 46) step(0, 1, cyc == b + 30);
        ck("s4_rise4", first_rise(b + 22, b + 40), b + 31);
        ck("s4_nostv", sum(2, b, b + 46), 0);
        ck("s4_five",  rises(0, b + 1, b + 46), 5);

        // 5: reset during the high phase, then restart
        step(1, 0, 0); step(1, 0, 0);
        b = cyc;
        step(0, 1, 0); step(0, 1, 0);
        step(1, 1, 0);
        while (cyc < b + 16) step(0, 1, 0);
        ck("s5_high_pre", pa[b + 2], 1);
        ck("s5_pwm0",     pa[b + 3], 0);
        ck("s5_idle",     ra[b + 3], 0);
        ck("s5_notick",   ta[b + 3], 0);
        ck("s5_restart",  first_rise(b + 3, b + 12), b + 4);
        ck("s5_full",     sum(0, b + 4, b + 13), 4);

        // 6: watchdog disabled instance, 1000 cycles without kicks
        step(1, 0, 0); step(1, 0, 0);
        b = cyc;
        for (int i = 0; i < 1000; i++) step(0, 1, 0);
        ck("s6_pulses", rises(4, b + 1, b + 1000), 100);
        ck("s6_nostv",  sum(5, b, b + 1000), 0);
        prev = -1;
        bad  = 0;
        for (int i = b + 1; i <= b + 1000; i++) begin
            if (pb[i] && !pb[i - 1]) begin
                if (prev >= 0 && i - prev != P) bad++;
                prev = i;
            end
        end
        ck("s6_spacing", bad, 0);

        // random traffic, checked cycle by cycle against the model
        en_r = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            bit r;
            bit k;
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 29) == 0) en_r = !en_r;
            k = ($urandom_range(0, 24) == 0);
            step(r, en_r, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
